// File: rtl/cpu_control_unit.sv
// rtl/cpu_control_unit.sv - 4-bit instruction sequencer: fetch/decode/exec against accumulator, carry and output port
module cpu_control_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       step,
  input  logic [7:0] rom_data,
  output logic [3:0] rom_addr,
  output logic [3:0] acc,
  output logic       carry,
  output logic [3:0] out_port,
  output logic       out_valid,
  output logic       halted,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_LDI  = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_SUBI = 4'h2;
  localparam logic [3:0] OP_OUT  = 4'h4;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_JC   = 4'hA;
  localparam logic [3:0] OP_JNC  = 4'hB;
  localparam logic [3:0] OP_HLT  = 4'hF;

  state_t     cur, nxt;
  logic [7:0] ir;
  logic [3:0] pc;
  logic       single;
  logic       fetch_en, exec_en, arm_step;
  logic [3:0] opcode, imm;
  logic [4:0] sum, diff;

  assign opcode   = ir[7:4];
  assign imm      = ir[3:0];
  assign sum      = {1'b0, acc} + {1'b0, imm};
  assign diff     = {1'b0, acc} - {1'b0, imm};
  assign rom_addr = pc;
  assign state    = cur;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur <= S_IDLE;
    else     cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    case (cur)
      S_IDLE:   if (run || step) nxt = S_FETCH;
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: nxt = S_EXEC;
      S_EXEC: begin
        if (opcode == OP_HLT)    nxt = S_HALT;
        else if (single || !run) nxt = S_IDLE;
        else                     nxt = S_FETCH;
      end
      S_HALT:   nxt = S_HALT;
      default:  nxt = S_IDLE;
    endcase
  end

  always_comb begin
    fetch_en = (cur == S_FETCH);
    exec_en  = (cur == S_EXEC);
    arm_step = (cur == S_IDLE) && !run && step;
    halted   = (cur == S_HALT);
  end

  // Jumps in EXEC overwrite the increment already applied during FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= 4'd0;
      ir        <= 8'h00;
      acc       <= 4'd0;
      carry     <= 1'b0;
      out_port  <= 4'd0;
      out_valid <= 1'b0;
      single    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (arm_step) single <= 1'b1;
      if (fetch_en) begin
        ir <= rom_data;
        pc <= pc + 4'd1;
      end
      if (exec_en) begin
        single <= 1'b0;
        case (opcode)
          OP_LDI:  acc <= imm;
          OP_ADDI: {carry, acc} <= sum;
          OP_SUBI: begin
            acc   <= diff[3:0];
            carry <= diff[4];
          end
          OP_OUT: begin
            out_port  <= acc;
            out_valid <= 1'b1;
          end
          OP_JMP:  pc <= imm;
          OP_JC:   if (carry)  pc <= imm;
          OP_JNC:  if (!carry) pc <= imm;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
// tb/tb_cpu_control_unit.sv - scoreboard bench for cpu_control_unit
module tb_cpu_control_unit;

  logic       clk = 1'b0;
  logic       rst, run, step;
  logic [7:0] rom_data;
  logic [3:0] rom_addr, acc, out_port;
  logic       carry, out_valid, halted;
  logic [2:0] state;
  logic [7:0] rom [16];

  assign rom_data = rom[rom_addr];
  always #5 clk = ~clk;

  cpu_control_unit dut (
    .clk(clk), .rst(rst), .run(run), .step(step), .rom_data(rom_data),
    .rom_addr(rom_addr), .acc(acc), .carry(carry), .out_port(out_port),
    .out_valid(out_valid), .halted(halted), .state(state)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [9:0] exp_q [$];
  logic [3:0] out_q [$];
  logic       retire_edge = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_ret(input logic h, input logic c, input logic [3:0] a, input logic [3:0] p);
    exp_q.push_back({h, c, a, p});
  endtask

  // An instruction retires on every clean EXEC edge; its result is visible at the next falling edge.
  always @(posedge clk) retire_edge <= (state == 3'd3) && !rst;

  always @(negedge clk) begin
    if (retire_edge) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_retire: got pc=%0h acc=%0h expected none", rom_addr, acc);
      end else begin
        check("retire{halted,carry,acc,pc}", {6'd0, halted, carry, acc, rom_addr}, {6'd0, exp_q.pop_front()});
      end
    end
    if (out_valid) begin
      if (out_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_out_valid: got out_port=%0h expected no pulse", out_port);
      end else begin
        check("out_port", {12'd0, out_port}, {12'd0, out_q.pop_front()});
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; step = 1'b0;
    for (int i = 0; i < 16; i++) rom[i] = 8'hF0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input string name);
    int n = 0;
    while (state !== s && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (state !== s) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: got state=%0d expected %0d", name, state, s);
    end
  endtask

  task automatic pulse_step();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  task automatic drain(input string name);
    @(negedge clk);
    check({name, "_pending_retires"}, 16'(exp_q.size()), 16'd0);
    check({name, "_pending_outputs"}, 16'(out_q.size()), 16'd0);
    exp_q.delete();
    out_q.delete();
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; step = 1'b0;
    for (int i = 0; i < 16; i++) rom[i] = 8'hF0;
    repeat (2) @(negedge clk);
    check("reset_state", {acc, rom_addr, out_port, carry, out_valid, halted, 1'b0},
          16'h0000);
    check("reset_fsm", {13'd0, state}, 16'd0);
    rst = 1'b0;

    // add with carry
    rom[0] = 8'h08; rom[1] = 8'h19;
    expect_ret(0, 0, 4'd8, 4'd1);
    expect_ret(0, 1, 4'd1, 4'd2);
    expect_ret(1, 1, 4'd1, 4'd3);
    run = 1'b1;
    wait_state(3'd4, "add");
    drain("add");

    // subtract with borrow, then taken JC
    do_reset();
    rom[0] = 8'h03; rom[1] = 8'h25; rom[2] = 8'hA6;
    expect_ret(0, 0, 4'd3, 4'd1);
    expect_ret(0, 1, 4'd14, 4'd2);
    expect_ret(0, 1, 4'd14, 4'd6);
    expect_ret(1, 1, 4'd14, 4'd7);
    run = 1'b1;
    wait_state(3'd4, "sub");
    drain("sub");

    // JNC not taken with carry set
    do_reset();
    rom[0] = 8'h0F; rom[1] = 8'h11; rom[2] = 8'h78; rom[8] = 8'hB2;
    expect_ret(0, 0, 4'd15, 4'd1);
    expect_ret(0, 1, 4'd0, 4'd2);
    expect_ret(0, 1, 4'd0, 4'd8);
    expect_ret(0, 1, 4'd0, 4'd9);
    expect_ret(1, 1, 4'd0, 4'd10);
    run = 1'b1;
    wait_state(3'd4, "jnc");
    drain("jnc");

    // single-step; a second pulse during DECODE must not queue
    do_reset();
    rom[0] = 8'h05; rom[1] = 8'h12;
    expect_ret(0, 0, 4'd5, 4'd1);
    pulse_step();
    repeat (3) @(negedge clk);
    check("step_back_to_idle", {13'd0, state}, 16'd0);
    expect_ret(0, 0, 4'd7, 4'd2);
    pulse_step();
    @(negedge clk);
    check("step_in_decode", {13'd0, state}, 16'd2);
    pulse_step();
    @(negedge clk);
    check("step_ignored{state,pc}", {9'd0, state, rom_addr}, {9'd0, 3'd0, 4'd2});
    repeat (5) @(negedge clk);
    check("step_still_idle{state,pc}", {9'd0, state, rom_addr}, {9'd0, 3'd0, 4'd2});
    drain("step");

    // OUT at address 15, pc wraps, HLT at 0 freezes everything
    do_reset();
    rom[0] = 8'h07; rom[1] = 8'h7F; rom[15] = 8'h40;
    expect_ret(0, 0, 4'd7, 4'd1);
    pulse_step();
    repeat (3) @(negedge clk);
    expect_ret(0, 0, 4'd7, 4'd15);
    pulse_step();
    repeat (3) @(negedge clk);
    check("jmp_to_15{state,pc}", {9'd0, state, rom_addr}, {9'd0, 3'd0, 4'd15});
    rom[0] = 8'hF0;
    expect_ret(0, 0, 4'd7, 4'd0);
    out_q.push_back(4'd7);
    expect_ret(1, 0, 4'd7, 4'd1);
    run = 1'b1;
    wait_state(3'd4, "wrap");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      run  = i[0];
      step = i[1];
    end
    run = 1'b0; step = 1'b0;
    check("halt_frozen{halted,state,pc}", {8'd0, halted, state, rom_addr}, {8'd0, 1'b1, 3'd4, 4'd1});
    check("halt_out_port", {12'd0, out_port}, 16'd7);
    drain("wrap");

    // asynchronous reset in the middle of an OUT EXEC cycle
    do_reset();
    rom[0] = 8'h05; rom[1] = 8'h40;
    expect_ret(0, 0, 4'd5, 4'd1);
    run = 1'b1;
    wait_state(3'd3, "ldi_exec");
    @(negedge clk);
    wait_state(3'd3, "out_exec");
    check("pre_reset_acc", {12'd0, acc}, 16'd5);
    #1 rst = 1'b1;
    #1 check("async_reset{acc,pc,out,carry,valid,state}",
             {acc, rom_addr, out_port, carry, out_valid, state[1:0]}, 16'h0000);
    check("async_reset_state", {13'd0, state}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    run = 1'b0;
    repeat (3) @(negedge clk);
    drain("rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
